// File: rtl/uart_sim_pkg.sv
// Shared constants for the simulation UART: register offsets within the
// 0x9A10_00xx page and bit positions inside the STATUS register.
package uart_sim_pkg;

    localparam logic [7:0] OFF_TXDATA  = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_RXDATA  = 8'h08;
    localparam logic [7:0] OFF_TXCOUNT = 8'h0C;

    localparam int ST_TX_EMPTY  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_TX_OVF    = 3;
    localparam int ST_RX_OVR    = 4;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/uart_sim_fifo.sv
// Synchronous byte FIFO for the UART transmit path. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_sim_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_sim_model.sv
// Simulation UART on the req/gnt/rvalid bus with a rate-limited TX FIFO drain.
// Define UART_SIM_PRINT_EN to echo every transmitted byte to the console.
module uart_sim_model
    import uart_sim_pkg::*;
#(
    parameter int TX_FIFO_DEPTH = 16,
    parameter int TX_DIV        = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        gnt,
    output logic        rvalid,
    output logic        err,
    output logic        tx_strobe_o,
    output logic [7:0]  tx_byte_o,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i
);

    localparam int DW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

    logic [7:0]                     off;
    logic                           rd;
    logic                           wr;
    logic                           bad_off;
    logic                           push_req;
    logic                           sts_clr;
    logic                           rx_rd;
    logic                           cnt_clr;
    logic                           tx_fire;
    logic                           ovf_set;
    logic [31:0]                    status;
    logic [31:0]                    rd_val;
    logic [DW-1:0]                  div_q;
    logic [31:0]                    txcount_q;
    logic                           tx_ovf_q;
    logic                           rx_ovr_q;
    logic                           rx_valid_q;
    logic [7:0]                     rx_byte_q;
    logic [7:0]                     fifo_rdata;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(TX_FIFO_DEPTH):0] fifo_count;
    logic                           unused_bits;

    assign off         = addr[7:0];
    assign unused_bits = ^{addr[31:8], wdata[31:8], be[3:1]};
    assign gnt         = req;
    assign rd          = req && !we;
    assign wr          = req && we;
    assign bad_off     = !(off inside {OFF_TXDATA, OFF_STATUS, OFF_RXDATA, OFF_TXCOUNT});
    assign push_req    = wr && (off == OFF_TXDATA) && be[0];
    assign sts_clr     = wr && (off == OFF_STATUS) && be[0];
    assign rx_rd       = rd && (off == OFF_RXDATA);
    assign cnt_clr     = wr && (off == OFF_TXCOUNT);
    assign tx_fire     = !fifo_empty && (div_q == DW'(TX_DIV - 1));
    // A full FIFO still takes the byte when the drain frees a slot this cycle.
    assign ovf_set     = push_req && fifo_full && !tx_fire;

    uart_sim_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .wdata  (wdata[7:0]),
        .pop    (tx_fire),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        status                       = '0;
        status[ST_TX_EMPTY]          = fifo_empty;
        status[ST_TX_FULL]           = fifo_full;
        status[ST_RX_VALID]          = rx_valid_q;
        status[ST_TX_OVF]            = tx_ovf_q;
        status[ST_RX_OVR]            = rx_ovr_q;
        status[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
        rd_val = '0;
        case (off)
            OFF_STATUS:  rd_val = status;
            OFF_RXDATA:  rd_val = {23'b0, rx_valid_q, rx_byte_q};
            OFF_TXCOUNT: rd_val = txcount_q;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid      <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            div_q       <= '0;
            tx_strobe_o <= 1'b0;
            tx_byte_o   <= '0;
            txcount_q   <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_byte_q   <= '0;
        end else begin
            rvalid <= req;
            err    <= req && bad_off;
            if (rd) rdata <= rd_val;

            if (fifo_empty || tx_fire) div_q <= '0;
            else                       div_q <= div_q + 1'b1;

            tx_strobe_o <= tx_fire;
            if (tx_fire) tx_byte_o <= fifo_rdata;

            if (cnt_clr)      txcount_q <= '0;
            else if (tx_fire) txcount_q <= txcount_q + 32'd1;

            // Setting events win over a same-cycle write-1-to-clear.
            if (sts_clr && wdata[ST_TX_OVF]) tx_ovf_q <= 1'b0;
            if (ovf_set)                     tx_ovf_q <= 1'b1;
            if (sts_clr && wdata[ST_RX_OVR]) rx_ovr_q <= 1'b0;
            if (rx_valid_i && rx_valid_q && !rx_rd) rx_ovr_q <= 1'b1;

            if (rx_valid_i) begin
                rx_valid_q <= 1'b1;
                rx_byte_q  <= rx_data_i;
            end else if (rx_rd) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_SIM_PRINT_EN
    always @(posedge clk) begin
        if (tx_strobe_o) $write("%c", tx_byte_o);
    end
`else
`endif

endmodule

// File: tb/tb_uart_sim_model.sv
// Directed bench for uart_sim_model: register vectors from a table plus
// hand-written TX timing, overflow and mid-operation reset sequences.
module tb_uart_sim_model;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;

    logic [31:0] rdata, s_rdata;
    logic        gnt, s_gnt, rvalid, s_rvalid, err, s_err;
    logic        tx_strobe_o, s_tx_strobe_o;
    logic [7:0]  tx_byte_o, s_tx_byte_o;

    int total = 0;
    int bad = 0;
    logic [31:0] last_rdata, last_rdata_s;
    logic        last_err, last_err_s;

    always #5 clk = ~clk;

    uart_sim_model #(.TX_FIFO_DEPTH(16), .TX_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .req(req), .addr(addr), .we(we), .be(be),
        .wdata(wdata), .rdata(rdata), .gnt(gnt), .rvalid(rvalid), .err(err),
        .tx_strobe_o(tx_strobe_o), .tx_byte_o(tx_byte_o),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i)
    );

    uart_sim_model #(.TX_FIFO_DEPTH(16), .TX_DIV(64)) dut_slow (
        .clk(clk), .resetn(resetn), .req(req), .addr(addr), .we(we), .be(be),
        .wdata(wdata), .rdata(s_rdata), .gnt(s_gnt), .rvalid(s_rvalid), .err(s_err),
        .tx_strobe_o(s_tx_strobe_o), .tx_byte_o(s_tx_byte_o),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bus(input logic w, input logic [7:0] a, input logic [3:0] b,
                             input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = {24'h9A1000, a};
        be    = b;
        wdata = d;
    endtask

    task automatic idle_bus();
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        rx_valid_i = 1'b0; rx_data_i = '0;
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [3:0] b,
                       input logic [31:0] d);
        drive_bus(w, a, b, d);
        #1;
        check("gnt", {31'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        idle_bus();
        check("rvalid", {31'b0, rvalid}, 32'd1);
        last_rdata   = rdata;
        last_err     = err;
        last_rdata_s = s_rdata;
        last_err_s   = s_err;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic rq, input logic w, input logic [7:0] a,
                                input logic [3:0] b, input logic [31:0] d, input logic rxv,
                                input logic [7:0] rxd, input logic e, input logic c,
                                input logic [31:0] r);
        vec_t v;
        v.req = rq; v.we = w; v.addr = a; v.be = b; v.wdata = d;
        v.rxv = rxv; v.rxd = rxd; v.exp_err = e; v.chk_rd = c; v.exp_rd = r;
        return v;
    endfunction

    initial begin
        int first_k, second_k, pulses;
        logic [7:0] first_b, second_b;

        // req we addr be wdata rxv rxd err chk rdata
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 32'h0,  1, 8'h5A, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h08, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h15A));
        vecs.push_back(mk(1, 0, 8'h08, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h05A));
        vecs.push_back(mk(1, 0, 8'h04, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 32'h0,  1, 8'h11, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 32'h0,  1, 8'h22, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h04, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h15));
        vecs.push_back(mk(1, 0, 8'h08, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h122));
        vecs.push_back(mk(1, 1, 8'h04, 4'h1, 32'h10, 0, 8'h00, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h04, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h1));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 32'h0,  1, 8'h33, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h08, 4'hF, 32'h0,  1, 8'h44, 0, 1, 32'h133));
        vecs.push_back(mk(1, 0, 8'h04, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h5));
        vecs.push_back(mk(1, 0, 8'h08, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h144));
        vecs.push_back(mk(1, 1, 8'h04, 4'h0, 32'hFF, 0, 8'h00, 0, 1, 32'h144));
        vecs.push_back(mk(1, 0, 8'h0C, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h3));
        vecs.push_back(mk(1, 1, 8'h0C, 4'h0, 32'h0,  0, 8'h00, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h0C, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 8'h20, 4'hF, 32'h0,  0, 8'h00, 1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 8'h00, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h0));
        vecs.push_back(mk(1, 1, 8'h24, 4'hF, 32'h1,  0, 8'h00, 1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 8'h08, 4'h1, 32'h99, 0, 8'h00, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h04, 4'hF, 32'h0,  0, 8'h00, 0, 1, 32'h1));

        #3;
        do_reset();
        check("reset rvalid", {31'b0, rvalid}, 32'd0);
        check("reset err", {31'b0, err}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset strobe", {31'b0, tx_strobe_o}, 32'd0);
        check("reset tx_byte", {24'b0, tx_byte_o}, 32'd0);
        bus(1'b0, 8'h04, 4'hF, 32'h0);
        check("reset status", last_rdata, 32'h1);

        // Single byte: strobe follows edge n+4, then TXCOUNT reads 1.
        bus(1'b1, 8'h00, 4'h1, 32'h41);
        check("tx write err", {31'b0, last_err}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) check("rvalid single pulse", {31'b0, rvalid}, 32'd0);
            check($sformatf("tx strobe cyc%0d", i), {31'b0, tx_strobe_o}, (i == 4) ? 32'd1 : 32'd0);
            if (i >= 4) check($sformatf("tx byte cyc%0d", i), {24'b0, tx_byte_o}, 32'h41);
        end
        bus(1'b0, 8'h0C, 4'hF, 32'h0);
        check("txcount one", last_rdata, 32'd1);

        // Two back-to-back bytes drain TX_DIV cycles apart.
        for (int j = 0; j < 2; j++) begin
            drive_bus(1'b1, 8'h00, 4'h1, 32'h42 + 32'(j));
            @(posedge clk); #1;
        end
        idle_bus();
        first_k = -1; second_k = -1; pulses = 0; first_b = '0; second_b = '0;
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk); #1;
            if (tx_strobe_o) begin
                pulses++;
                if (first_k < 0) begin first_k = k; first_b = tx_byte_o; end
                else begin second_k = k; second_b = tx_byte_o; end
            end
        end
        check("b2b pulses", 32'(pulses), 32'd2);
        check("b2b first cycle", 32'(first_k), 32'd4);
        check("b2b second cycle", 32'(second_k), 32'd8);
        check("b2b first byte", {24'b0, first_b}, 32'h42);
        check("b2b second byte", {24'b0, second_b}, 32'h43);

        foreach (vecs[i]) begin
            req = vecs[i].req; we = vecs[i].we; addr = {24'h9A1000, vecs[i].addr};
            be = vecs[i].be; wdata = vecs[i].wdata;
            rx_valid_i = vecs[i].rxv; rx_data_i = vecs[i].rxd;
            @(posedge clk); #1;
            idle_bus();
            check($sformatf("vec%0d rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].req});
            check($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
        end

        // Overflow on the slow instance: 17 writes, no drain in between.
        do_reset();
        for (int j = 0; j < 17; j++) begin
            drive_bus(1'b1, 8'h00, 4'h1, 32'(j));
            @(posedge clk); #1;
        end
        idle_bus();
        bus(1'b0, 8'h04, 4'hF, 32'h0);
        check("ovf status", last_rdata_s, 32'h100A);
        check("ovf status err", {31'b0, last_err_s}, 32'd0);
        bus(1'b1, 8'h04, 4'h1, 32'h8);
        bus(1'b0, 8'h04, 4'hF, 32'h0);
        check("ovf cleared", last_rdata_s, 32'h1002);
        check("slow no strobe", {31'b0, s_tx_strobe_o}, 32'd0);

        // Asynchronous reset with bytes queued and a strobe in flight.
        do_reset();
        for (int j = 0; j < 5; j++) begin
            drive_bus(1'b1, 8'h00, 4'h1, 32'h61 + 32'(j));
            @(posedge clk); #1;
        end
        idle_bus();
        check("pre-reset strobe", {31'b0, tx_strobe_o}, 32'd1);
        check("pre-reset byte", {24'b0, tx_byte_o}, 32'h61);
        #2 resetn = 1'b0;
        #1;
        check("async strobe", {31'b0, tx_strobe_o}, 32'd0);
        check("async byte", {24'b0, tx_byte_o}, 32'd0);
        check("async rvalid", {31'b0, rvalid}, 32'd0);
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (tx_strobe_o) pulses++;
        end
        check("post-reset pulses", 32'(pulses), 32'd0);
        bus(1'b0, 8'h04, 4'hF, 32'h0);
        check("post-reset status", last_rdata, 32'h1);
        bus(1'b0, 8'h0C, 4'hF, 32'h0);
        check("post-reset txcount", last_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
